// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART frame parser
package uart_frame_pkg;

  // Parser states: waiting for SOF, then command, length, payload, checksum
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } state_t;

  // Abort reasons reported on ErrCode together with FrameErr
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  // Start-of-frame marker used unless the instance overrides it
  localparam logic [7:0] DEFAULT_SOF = 8'hAA;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload buffer, one write port and one registered read port
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage is never cleared; a new frame simply overwrites the old payload
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to raddr is seen on the following read
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/CMD/LEN/payload/CHK frame parser behind the UART receiver
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF         = DEFAULT_SOF,
  parameter int         TIMEOUT_CYC = 50000,
  localparam int        LW          = $clog2(MAX_LEN + 1),
  localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int        TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [7:0]    RxData,
  input  logic          RxDone,
  output logic [7:0]    Cmd,
  output logic [LW-1:0] Len,
  output logic          FrameValid,
  output logic          FrameErr,
  output logic [1:0]    ErrCode,
  output logic          Busy,
  input  logic [AW-1:0] RdAddr,
  output logic [7:0]    RdData
);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC);

  state_t        state;
  logic [7:0]    cmd_w;
  logic [LW-1:0] len_w;
  logic [AW-1:0] idx;
  logic [7:0]    chk_acc;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          buf_we;

  // A byte arriving on the expiry cycle takes priority over the timeout
  assign tmo_hit = (state != IDLE) && !RxDone && (tmo_cnt == TMO_LAST);
  assign buf_we  = RxDone && (state == DATA);
  assign Busy    = (state != IDLE);

  // Inter-byte silence counter: idle outside a frame, restarted by every byte
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || RxDone) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Frame FSM with checksum accumulation, payload indexing and result pulses
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      cmd_w      <= 8'h00;
      len_w      <= '0;
      idx        <= '0;
      chk_acc    <= 8'h00;
      Cmd        <= 8'h00;
      Len        <= '0;
      FrameValid <= 1'b0;
      FrameErr   <= 1'b0;
      ErrCode    <= 2'd0;
    end else begin
      FrameValid <= 1'b0;
      FrameErr   <= 1'b0;
      if (tmo_hit) begin
        FrameErr <= 1'b1;
        ErrCode  <= ERR_TMO;
        state    <= IDLE;
      end else if (RxDone) begin
        case (state)
          IDLE: begin
            if (RxData == SOF) begin
              idx   <= '0;
              state <= CMD;
            end
          end
          CMD: begin
            cmd_w   <= RxData;
            chk_acc <= RxData;
            state   <= LEN;
          end
          LEN: begin
            if (RxData > MAX_LEN_B) begin
              FrameErr <= 1'b1;
              ErrCode  <= ERR_LEN;
              state    <= IDLE;
            end else begin
              len_w   <= RxData[LW-1:0];
              chk_acc <= chk_acc ^ RxData;
              state   <= (RxData == 8'h00) ? CHK : DATA;
            end
          end
          DATA: begin
            chk_acc <= chk_acc ^ RxData;
            idx     <= idx + AW'(1);
            if (LW'(idx) == len_w - LW'(1)) begin
              state <= CHK;
            end
          end
          CHK: begin
            if (RxData == chk_acc) begin
              FrameValid <= 1'b1;
              Cmd        <= cmd_w;
              Len        <= len_w;
            end else begin
              FrameErr <= 1'b1;
              ErrCode  <= ERR_CHK;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (Clk),
    .rst   (Rst),
    .we    (buf_we),
    .waddr (idx),
    .wdata (RxData),
    .raddr (RdAddr),
    .rdata (RdData)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         T       = 40;
  localparam logic [7:0] SOF     = 8'hAA;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] RxData;
  logic       RxDone;
  logic [7:0] Cmd;
  logic [4:0] Len;
  logic       FrameValid;
  logic       FrameErr;
  logic [1:0] ErrCode;
  logic       Busy;
  logic [3:0] RdAddr;
  logic [7:0] RdData;

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .SOF         (SOF),
    .TIMEOUT_CYC (T)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .RxData     (RxData),
    .RxDone     (RxDone),
    .Cmd        (Cmd),
    .Len        (Len),
    .FrameValid (FrameValid),
    .FrameErr   (FrameErr),
    .ErrCode    (ErrCode),
    .Busy       (Busy),
    .RdAddr     (RdAddr),
    .RdData     (RdData)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [7:0] cmd;
    logic [4:0] len;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a frame is just the list of bytes seen after SOF
  bit         in_frame = 1'b0;
  logic [7:0] frm[$];
  int         last_s = 0;
  logic [7:0] good_cmd = 8'h00;
  logic [4:0] good_len = 5'd0;
  logic [7:0] good_pl[$];
  bit         new_good = 1'b0;

  task automatic push_exp(input bit is_err, input logic [1:0] code, input int at);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.cmd    = good_cmd;
    e.len    = good_len;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int s);
    logic [7:0] x;
    logic [7:0] l;
    if (!in_frame) begin
      if (b == SOF) begin
        in_frame = 1'b1;
        frm.delete();
      end
    end else begin
      frm.push_back(b);
      l = (frm.size() >= 2) ? frm[1] : 8'h00;
      if (frm.size() == 2 && int'(l) > MAX_LEN) begin
        push_exp(1'b1, 2'd1, s);
        in_frame = 1'b0;
      end else if (frm.size() >= 2 && frm.size() == int'(l) + 3) begin
        x = 8'h00;
        for (int i = 0; i < frm.size() - 1; i++) x = x ^ frm[i];
        if (x == b) begin
          good_cmd = frm[0];
          good_len = l[4:0];
          good_pl.delete();
          for (int i = 2; i < frm.size() - 1; i++) good_pl.push_back(frm[i]);
          new_good = 1'b1;
          push_exp(1'b0, 2'd0, s);
        end else begin
          push_exp(1'b1, 2'd2, s);
        end
        in_frame = 1'b0;
      end
    end
    last_s = s;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One clock of stimulus; the model sees the same edge the DUT samples
  task automatic step(input bit strobe, input logic [7:0] b);
    int edge_c;
    edge_c = cyc + 1;
    if (in_frame && !strobe && edge_c == last_s + T + 1) begin
      push_exp(1'b1, 2'd3, edge_c);
      in_frame = 1'b0;
    end
    if (strobe) model_byte(b, edge_c);
    RxDone = strobe;
    RxData = strobe ? b : 8'($urandom);
    tick();
    chk("busy", Busy, in_frame);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic after_frame();
    idle(2);
    if (new_good) begin
      for (int i = 0; i < good_pl.size(); i++) begin
        RdAddr = 4'(i);
        step(1'b0, 8'h00);
        chk("rd_data", RdData, good_pl[i]);
      end
      new_good = 1'b0;
    end
  endtask

  task automatic do_reset();
    Rst      = 1'b1;
    RxDone   = 1'b0;
    in_frame = 1'b0;
    good_cmd = 8'h00;
    good_len = 5'd0;
    new_good = 1'b0;
    tick();
    Rst = 1'b0;
    chk("rst_cmd", Cmd, 8'h00);
    chk("rst_len", Len, 5'd0);
    chk("rst_busy", Busy, 1'b0);
  endtask

  // Monitor: pops one expectation per result pulse and checks its content and timing
  always @(negedge Clk) begin
    if (FrameValid && FrameErr) begin
      chk("both_pulses", 32'd1, 32'd0);
    end else if (FrameValid || FrameErr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {FrameValid, FrameErr, ErrCode}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", FrameErr, e.is_err);
        chk("pulse_cycle", cyc, e.at);
        chk("cmd", Cmd, e.cmd);
        chk("len", Len, e.len);
        if (e.is_err) chk("err_code", ErrCode, e.code);
      end
    end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      chk("missing_pulse", cyc, exp_q[0].at);
      void'(exp_q.pop_front());
    end
  end

  function automatic int rgap();
    return ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 2);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, n, x, b;
    int kind, cut;
    Rst = 1'b1; RxDone = 1'b0; RxData = 8'h00; RdAddr = 4'd0;
    repeat (3) tick();
    Rst = 1'b0;
    chk("reset_cmd", Cmd, 8'h00);
    chk("reset_len", Len, 5'd0);
    chk("reset_valid", FrameValid, 1'b0);
    chk("reset_err", FrameErr, 1'b0);
    chk("reset_code", ErrCode, 2'd0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_rd", RdData, 8'h00);

    // Good frame, then the same frame with a bad checksum
    send(8'hAA,0); send(8'h10,0); send(8'h03,0); send(8'h01,0); send(8'h02,0); send(8'h03,0); send(8'h13,0);
    after_frame();
    send(8'hAA,0); send(8'h10,0); send(8'h03,0); send(8'h01,0); send(8'h02,0); send(8'h03,0); send(8'h14,0);
    after_frame();

    // Oversized length, then an empty-payload frame
    send(8'hAA,1); send(8'h10,1); send(8'h11,0);
    after_frame();
    send(8'hAA,0); send(8'h20,0); send(8'h00,0); send(8'h20,0);
    after_frame();

    // Timeout, then resync past a stray byte
    send(8'hAA,0); send(8'h10,0);
    idle(T + 5);
    send(8'h55,0); send(8'hAA,0); send(8'h30,0); send(8'h00,0); send(8'h30,0);
    after_frame();

    // Bytes landing exactly on the expiry cycle, then one cycle too late
    send(8'hAA,T); send(8'h40,T); send(8'h01,T); send(8'h05,T); send(8'h44,0);
    after_frame();
    send(8'hAA,0); send(8'h41,T + 1); send(8'h00,0); send(8'h41,0);
    after_frame();

    // Back-to-back strobes with SOF inside the payload
    send(8'hAA,0); send(8'h10,0); send(8'h01,0); send(8'hAA,0); send(8'hBB,0);
    after_frame();

    // Reset mid-frame, stragglers ignored, then a normal frame
    send(8'hAA,0); send(8'h10,0); send(8'h02,0); send(8'h01,0);
    do_reset();
    send(8'h02,0); send(8'h5A,0);
    idle(3);
    send(8'hAA,0); send(8'h50,0); send(8'h02,0); send(8'h0A,0); send(8'h0B,0); send(8'h53,0);
    after_frame();

    // Randomized mix of good, corrupt, oversized, stray and truncated frames
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 5);
      c = 8'($urandom);
      if (kind == 4) begin
        b = 8'($urandom);
        if (b == SOF) b = 8'h55;
        send(b, rgap());
      end else if (kind == 3) begin
        send(SOF, rgap()); send(c, rgap()); send(8'($urandom_range(MAX_LEN + 1, 255)), rgap());
      end else begin
        n = 8'($urandom_range(0, MAX_LEN));
        cut = (kind == 5) ? $urandom_range(0, int'(n) + 1) : int'(n) + 2;
        x = c ^ n;
        send(SOF, rgap());
        send(c, rgap());
        if (cut >= 1) send(n, rgap());
        for (int i = 0; i < int'(n) && i + 2 <= cut; i++) begin
          b = 8'($urandom);
          x = x ^ b;
          send(b, rgap());
        end
        if (kind == 5) idle(T + 3);
        else if (kind == 2) send(x ^ 8'($urandom_range(1, 255)), rgap());
        else send(x, rgap());
      end
      after_frame();
    end

    idle(T + 5);
    chk("pending_events", exp_q.size(), 32'd0);
    chk("final_busy", Busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
